// File: rtl/interval_timer.sv
// Interval timer: prescaled tick counter with a programmable target, in one-shot or
// auto-reload mode. Raises a one-cycle done pulse when the count reaches the target.
module interval_timer #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 2000,
   parameter int WIDTH   = 12
) (
   input  logic             clk_50M,
   input  logic             i_Reset,
   input  logic             i_Start,
   input  logic             i_Stop,
   input  logic             i_Pause,
   input  logic             i_Clear,
   input  logic             i_Periodic,
   input  logic [WIDTH-1:0] i_Target,
   output logic [WIDTH-1:0] o_Count,
   output logic             o_Busy,
   output logic             o_Tick,
   output logic             o_Done
);

   localparam int PRESC = CLK_HZ / TICK_HZ;
   localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

   generate
      if (PRESC < 1 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_presc
         $error("interval_timer: CLK_HZ/TICK_HZ must be an integer >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;

   state_t           state_reg, state_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] target_reg, target_next;
   logic             periodic_reg, periodic_next;
   logic             wrap_reg, wrap_next;
   logic             tick_reg, tick_next;
   logic             done_reg, done_next;
   logic             busy_reg;
   logic [WIDTH-1:0] base_count;
   logic [WIDTH-1:0] inc_count;

   always_ff @(posedge clk_50M) begin
      if (i_Reset) begin
         state_reg    <= ST_IDLE;
         presc_reg    <= '0;
         count_reg    <= '0;
         target_reg   <= '0;
         periodic_reg <= 1'b0;
         wrap_reg     <= 1'b0;
         tick_reg     <= 1'b0;
         done_reg     <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         presc_reg    <= presc_next;
         count_reg    <= count_next;
         target_reg   <= target_next;
         periodic_reg <= periodic_next;
         wrap_reg     <= wrap_next;
         tick_reg     <= tick_next;
         done_reg     <= done_next;
         busy_reg     <= (state_next != ST_IDLE);
      end
   end

   always_comb begin
      state_next    = state_reg;
      presc_next    = presc_reg;
      count_next    = count_reg;
      target_next   = target_reg;
      periodic_next = periodic_reg;
      wrap_next     = wrap_reg;
      tick_next     = 1'b0;
      done_next     = 1'b0;
      // In periodic mode the count shows the target for the done cycle, then restarts at 0.
      base_count    = wrap_reg ? '0 : count_reg;
      inc_count     = base_count + WIDTH'(1);

      if (i_Start) begin
         state_next    = ST_RUN;
         presc_next    = '0;
         count_next    = '0;
         wrap_next     = 1'b0;
         target_next   = i_Target;
         periodic_next = i_Periodic;
      end else if (i_Stop && state_reg != ST_IDLE) begin
         state_next = ST_IDLE;
         presc_next = '0;
         wrap_next  = 1'b0;
      end else if (i_Clear) begin
         presc_next = '0;
         count_next = '0;
         wrap_next  = 1'b0;
      end else if (state_reg != ST_IDLE) begin
         if (i_Pause) begin
            state_next = ST_PAUSED;
         end else if (target_reg == '0) begin
            // A zero target finishes immediately in either mode rather than free-running.
            state_next = ST_IDLE;
            presc_next = '0;
            done_next  = 1'b1;
         end else begin
            state_next = ST_RUN;
            wrap_next  = 1'b0;
            if (presc_reg == PRESC_LAST) begin
               presc_next = '0;
               count_next = inc_count;
               tick_next  = 1'b1;
               if (inc_count == target_reg) begin
                  done_next = 1'b1;
                  if (periodic_reg) begin
                     wrap_next = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end else begin
               presc_next = presc_reg + PW'(1);
               count_next = base_count;
            end
         end
      end
   end

   assign o_Count = count_reg;
   assign o_Busy  = busy_reg;
   assign o_Tick  = tick_reg;
   assign o_Done  = done_reg;

endmodule
